// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and constants for the regfile write-port arbiter
package rf_arb_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [4:0] LAST_REG = 5'(NREGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// rtl/rf_wr_arbiter_if.sv - writeback in, regfile write out and status of the write-port arbiter
interface rf_wr_arbiter_if #(
    parameter int XLEN = 32
);

    logic            clr_req;
    logic            wb_wren;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;

    logic            rf_wren;
    logic [4:0]      rf_addr;
    logic [XLEN-1:0] rf_data;
    logic            stall;
    logic            busy;
    logic            clr_done;
    logic            ovf_err;

    modport master (
        output clr_req, wb_wren, wb_addr, wb_data,
        input  rf_wren, rf_addr, rf_data, stall, busy, clr_done, ovf_err
    );

    modport slave (
        input  clr_req, wb_wren, wb_addr, wb_data,
        output rf_wren, rf_addr, rf_data, stall, busy, clr_done, ovf_err
    );

endinterface

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - hold buffer for writebacks that arrive while the port is taken
module rf_wb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  wb_entry_t                wdata,
    output wb_entry_t                rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full buffer only lands if the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && !flush && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// rtl/rf_wr_arbiter.sv - owns the regfile write port: passthrough, x1..x31 clear, buffered replay
module rf_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int XLEN       = rf_arb_pkg::XLEN,
    parameter int NREGS      = rf_arb_pkg::NREGS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    rf_wr_arbiter_if.slave   bus
);

    localparam logic [4:0] LAST = 5'(NREGS - 1);

    state_t                      state_q, state_d;
    logic [4:0]                  cnt_q, cnt_d;
    logic                        ovf_q, ovf_d;

    logic                        wb_valid;
    logic                        push, pop, flush;
    logic                        full, empty;
    logic [$clog2(FIFO_DEPTH):0] count;
    wb_entry_t                   entry, head;

    logic                        wren;
    logic [4:0]                  addr;
    logic [XLEN-1:0]             data;

    assign wb_valid = bus.wb_wren && (bus.wb_addr != 5'd0);
    assign entry    = '{addr: bus.wb_addr, data: bus.wb_data};

    rf_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (i_clk),
        .resetn (i_reset),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .wdata  (entry),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        wren    = 1'b0;
        addr    = '0;
        data    = '0;

        case (state_q)
            IDLE: begin
                wren = wb_valid;
                addr = bus.wb_addr;
                data = bus.wb_data;
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = 5'd1;
                end
            end
            CLEAR: begin
                wren = 1'b1;
                addr = cnt_q;
                if (bus.clr_req) begin
                    flush = 1'b1;
                    cnt_d = 5'd1;
                end else begin
                    push = wb_valid;
                    if (cnt_q == LAST) begin
                        state_d = (!empty || push) ? DRAIN : IDLE;
                        cnt_d   = 5'd1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            DRAIN: begin
                wren = 1'b1;
                addr = head.addr;
                data = head.data;
                if (bus.clr_req) begin
                    // The restarted clear rewrites every register, so the buffer is moot.
                    flush   = 1'b1;
                    state_d = CLEAR;
                    cnt_d   = 5'd1;
                end else begin
                    push = wb_valid;
                    pop  = 1'b1;
                    if (count == ($clog2(FIFO_DEPTH) + 1)'(1) && !push) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ovf_d = ovf_q || (push && full && !pop);
    end

    // Outputs are forced low while reset is asserted, not just after it is sampled.
    assign bus.rf_wren  = i_reset && wren;
    assign bus.rf_addr  = i_reset ? addr : 5'd0;
    assign bus.rf_data  = i_reset ? data : '0;
    assign bus.stall    = i_reset && (state_q != IDLE);
    assign bus.busy     = i_reset && (state_q == CLEAR);
    assign bus.clr_done = i_reset && (state_q == CLEAR) && (cnt_q == LAST);
    assign bus.ovf_err  = i_reset && ovf_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb/tb_rf_wr_arbiter.sv - scoreboard bench for the regfile write-port arbiter
module tb_rf_wr_arbiter;
    import rf_arb_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    rf_wr_arbiter_if #(.XLEN(32)) bus ();

    rf_wr_arbiter #(
        .XLEN       (32),
        .NREGS      (32),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk   (clk),
        .i_reset (resetn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    wb_entry_t exp_q [$];
    int tests_run = 0;
    int tests_failed = 0;

    // Every regfile write the DUT issues must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.rf_wren === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", bus.rf_addr, bus.rf_data);
            end else begin
                wb_entry_t e;
                e = exp_q.pop_front();
                if ({bus.rf_addr, bus.rf_data} !== {e.addr, e.data}) begin
                    tests_failed++;
                    $display("FAIL write_value: got addr=%0d data=%h, expected addr=%0d data=%h", bus.rf_addr, bus.rf_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic drive(input logic clr, input logic wren, input logic [4:0] a, input logic [31:0] d);
        bus.clr_req = clr;
        bus.wb_wren = wren;
        bus.wb_addr = a;
        bus.wb_data = d;
    endtask

    task automatic advance;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
        wb_entry_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic clear_step(input int c, input logic clr, input logic wren, input logic [4:0] a, input logic [31:0] d);
        drive(clr, wren, a, d);
        expect_write(5'(c), 32'd0);
        @(negedge clk);
        tests_run++;
        if ({bus.busy, bus.stall, bus.clr_done} !== {2'b11, (c == int'(LAST_REG))}) begin
            tests_failed++;
            $display("FAIL clear_flags c=%0d: got busy/stall/done=%b, expected %b", c, {bus.busy, bus.stall, bus.clr_done}, {2'b11, (c == int'(LAST_REG))});
        end
        advance();
    endtask

    task automatic drain_step(input logic [4:0] a, input logic [31:0] d);
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        expect_write(a, d);
        @(negedge clk);
        tests_run++;
        if ({bus.stall, bus.busy} !== 2'b10) begin
            tests_failed++;
            $display("FAIL drain_flags: got stall/busy=%b, expected 10", {bus.stall, bus.busy});
        end
        advance();
    endtask

    task automatic idle_check;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        tests_run++;
        if ({bus.stall, bus.busy, bus.rf_wren} !== 3'b000) begin
            tests_failed++;
            $display("FAIL idle_flags: got stall/busy/wren=%b, expected 000", {bus.stall, bus.busy, bus.rf_wren});
        end
        advance();
    endtask

    task automatic queue_empty_check(input string name);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_missing_writes: got %0d writes outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic start_clear;
        drive(1'b1, 1'b0, 5'd0, 32'd0);
        advance();
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        tests_run++;
        if ({bus.rf_wren, bus.rf_addr, bus.rf_data, bus.stall, bus.busy, bus.clr_done, bus.ovf_err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs_during: got wren=%b addr=%0d data=%h, expected all zero", bus.rf_wren, bus.rf_addr, bus.rf_data);
        end
        advance();
        advance();
        resetn = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        tests_run++;
        if ({bus.rf_wren, bus.rf_addr, bus.rf_data, bus.stall, bus.busy, bus.clr_done, bus.ovf_err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs_after: got wren=%b stall=%b ovf=%b, expected all zero", bus.rf_wren, bus.stall, bus.ovf_err);
        end
        advance();
    endtask

    task automatic test_passthrough;
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        expect_write(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        tests_run++;
        if (bus.stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL passthrough_stall: got %b, expected 0", bus.stall);
        end
        advance();
        drive(1'b0, 1'b1, 5'd0, 32'h1234);
        @(negedge clk);
        tests_run++;
        if (bus.rf_wren !== 1'b0) begin
            tests_failed++;
            $display("FAIL passthrough_x0: got rf_wren=%b, expected 0", bus.rf_wren);
        end
        advance();
        queue_empty_check("passthrough");
    endtask

    task automatic test_clear;
        start_clear();
        for (int c = 1; c <= 31; c++) clear_step(c, 1'b0, 1'b0, 5'd0, 32'd0);
        idle_check();
        queue_empty_check("clear");
    endtask

    task automatic test_replay;
        start_clear();
        for (int c = 1; c <= 31; c++) begin
            case (c)
                2:       clear_step(c, 1'b0, 1'b1, 5'd3, 32'h11);
                5:       clear_step(c, 1'b0, 1'b1, 5'd7, 32'h22);
                8:       clear_step(c, 1'b0, 1'b1, 5'd3, 32'h33);
                9:       clear_step(c, 1'b0, 1'b1, 5'd0, 32'h44);
                default: clear_step(c, 1'b0, 1'b0, 5'd0, 32'd0);
            endcase
        end
        drain_step(5'd3, 32'h11);
        drain_step(5'd7, 32'h22);
        drain_step(5'd3, 32'h33);
        idle_check();
        queue_empty_check("replay");
    endtask

    task automatic test_overflow;
        tests_run++;
        if (bus.ovf_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_before: got %b, expected 0", bus.ovf_err);
        end
        start_clear();
        for (int c = 1; c <= 31; c++) begin
            if (c >= 2 && c <= 6) clear_step(c, 1'b0, 1'b1, 5'(8 + c), 32'hA0 + 32'(c));
            else                  clear_step(c, 1'b0, 1'b0, 5'd0, 32'd0);
            if (c == 6) begin
                tests_run++;
                if (bus.ovf_err !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL ovf_set: got %b, expected 1", bus.ovf_err);
                end
            end
        end
        for (int k = 2; k <= 5; k++) drain_step(5'(8 + k), 32'hA0 + 32'(k));
        idle_check();
        tests_run++;
        if (bus.ovf_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_sticky: got %b, expected 1", bus.ovf_err);
        end
        queue_empty_check("overflow");
    endtask

    task automatic test_restart;
        start_clear();
        for (int c = 1; c <= 10; c++) begin
            case (c)
                2:       clear_step(c, 1'b0, 1'b1, 5'd5, 32'h55);
                3:       clear_step(c, 1'b0, 1'b1, 5'd6, 32'h66);
                10:      clear_step(c, 1'b1, 1'b1, 5'd20, 32'h99);
                default: clear_step(c, 1'b0, 1'b0, 5'd0, 32'd0);
            endcase
        end
        for (int c = 1; c <= 31; c++) clear_step(c, 1'b0, 1'b0, 5'd0, 32'd0);
        idle_check();
        idle_check();
        queue_empty_check("restart");
    endtask

    task automatic test_reset_mid_drain;
        start_clear();
        for (int c = 1; c <= 31; c++) begin
            case (c)
                5:       clear_step(c, 1'b0, 1'b1, 5'd1, 32'hAAAA);
                6:       clear_step(c, 1'b0, 1'b1, 5'd2, 32'hBBBB);
                7:       clear_step(c, 1'b0, 1'b1, 5'd4, 32'hCCCC);
                default: clear_step(c, 1'b0, 1'b0, 5'd0, 32'd0);
            endcase
        end
        drain_step(5'd1, 32'hAAAA);
        resetn = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        tests_run++;
        if ({bus.rf_wren, bus.rf_addr, bus.rf_data, bus.stall, bus.busy, bus.clr_done, bus.ovf_err} !== '0) begin
            tests_failed++;
            $display("FAIL mid_drain_reset_outputs: got wren=%b addr=%0d stall=%b ovf=%b, expected all zero", bus.rf_wren, bus.rf_addr, bus.stall, bus.ovf_err);
        end
        advance();
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) idle_check();
        tests_run++;
        if (bus.ovf_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_after_reset: got %b, expected 0", bus.ovf_err);
        end
        queue_empty_check("reset_mid_drain");
    endtask

    initial begin
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        test_reset();
        test_passthrough();
        test_clear();
        test_replay();
        test_overflow();
        test_restart();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
